// File: rtl/serial_digit_adder.sv
// ============================================================================
// Module   : serial_digit_adder
// Brief    : Digit-serial add/subtract, DIGIT bits per clock, LSB digit first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_digit_adder #(
    parameter int WIDTH = 64,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic               done_q, done_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [DIGIT:0]     w_digit;
    logic [WIDTH-1:0]   w_res_shift;

    // Single DIGIT-bit carry-chain slice shared by every digit position.
    assign w_digit = {1'b0, a_sr_q[DIGIT-1:0]}
                   + {1'b0, b_sr_q[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, carry_q};

    generate
        if (DIGIT == WIDTH) begin : g_single_digit
            assign w_res_shift = w_digit[DIGIT-1:0];
        end else begin : g_multi_digit
            assign w_res_shift = {w_digit[DIGIT-1:0], res_q[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        done_d  = 1'b0;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Subtraction is A + ~B + ~borrow_in.
                    a_sr_d  = a;
                    b_sr_d  = b ^ {WIDTH{sub}};
                    carry_d = cin ^ sub;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1] ^ sub;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sr_d  = a_sr_q >> DIGIT;
                b_sr_d  = b_sr_q >> DIGIT;
                res_d   = w_res_shift;
                carry_d = w_digit[DIGIT];
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_DIGIT) begin
                    sum_d   = w_res_shift;
                    cout_d  = w_digit[DIGIT];
                    ovf_d   = (a_msb_q == b_msb_q) && (w_res_shift[WIDTH-1] != a_msb_q);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_digit_adder.sv
// ============================================================================
// Module   : tb_serial_digit_adder
// Brief    : Scoreboard bench over four WIDTH/DIGIT configurations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_digit_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic fin [4];

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar k = 0; k < 4; k++) begin : g_cfg
        localparam int W = (k == 0) ? 64 : 8;
        localparam int D = (k == 0) ? 8 : (k == 1) ? 1 : (k == 2) ? 8 : 4;
        localparam int N = W / D;

        logic         rst   = 1'b1;
        logic         start = 1'b0;
        logic         cin   = 1'b0;
        logic         sub   = 1'b0;
        logic [W-1:0] a     = '0;
        logic [W-1:0] b     = '0;
        logic         busy, done, cout, ovf;
        logic [W-1:0] sum;

        logic [W+1:0] exp_q [$];
        int           iss_q [$];

        serial_digit_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
            .clk  (clk),
            .rst  (rst),
            .start(start),
            .a    (a),
            .b    (b),
            .cin  (cin),
            .sub  (sub),
            .busy (busy),
            .done (done),
            .sum  (sum),
            .cout (cout),
            .ovf  (ovf)
        );

        // Reference: exact signed/unsigned integer arithmetic in W+2 bits.
        function automatic logic [W+1:0] model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                               input logic fc, input logic fs);
            logic signed [W+1:0] sa, sb, r, maxp, minn;
            logic        [W+1:0] ua, ub, uc, t;
            logic                co, ov;
            sa   = signed'({{2{fa[W-1]}}, fa});
            sb   = signed'({{2{fb[W-1]}}, fb});
            ua   = {2'b00, fa};
            ub   = {2'b00, fb};
            uc   = {{(W+1){1'b0}}, fc};
            maxp = signed'({3'b000, {(W-1){1'b1}}});
            minn = ~maxp;
            if (fs) begin
                r  = sa - sb - signed'(uc);
                co = (ua >= ub + uc);
            end else begin
                r  = sa + sb + signed'(uc);
                t  = ua + ub + uc;
                co = t[W];
            end
            ov = (r > maxp) || (r < minn);
            return {co, ov, r[W-1:0]};
        endfunction

        task automatic chk(input string nm, input logic [W+1:0] act, input logic [W+1:0] expv);
            checks++;
            if (act !== expv) begin
                errors++;
                $display("FAIL %s cfg%0d (W=%0d D=%0d): got %h want %h", nm, k, W, D, act, expv);
            end
        endtask

        task automatic tick();
            @(posedge clk);
            #1;
        endtask

        task automatic issue(input logic [W-1:0] fa, input logic [W-1:0] fb,
                             input logic fc, input logic fs);
            a = fa; b = fb; cin = fc; sub = fs; start = 1'b1;
            tick();
            start = 1'b0;
            exp_q.push_back(model(fa, fb, fc, fs));
            iss_q.push_back(cyc);
        endtask

        task automatic wait_done();
            int t = 0;
            while (!done && t < N + 8) begin
                tick();
                t++;
            end
            chk("done_seen", (W+2)'(done), (W+2)'(1));
        endtask

        function automatic logic [W-1:0] rnd_op();
            logic [63:0] r;
            r = {$urandom, $urandom};
            case ($urandom % 8)
                0: r = '1;
                1: r = {1'b0, {63{1'b1}}} >> (64 - W);
                2: r = 64'(1) << (W - 1);
                3: r = '0;
                default: ;
            endcase
            return r[W-1:0];
        endfunction

        // Monitor: pops the scoreboard whenever the DUT signals completion.
        initial begin
            logic [W+1:0] e;
            int           ic;
            forever begin
                @(negedge clk);
                if (!rst) chk("busy_done_excl", (W+2)'(busy & done), '0);
                if (done) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done cfg%0d: got done=1 want no pending op", k);
                    end else begin
                        e  = exp_q.pop_front();
                        ic = iss_q.pop_front();
                        chk("result", {cout, ovf, sum}, e);
                        chk("latency", (W+2)'(cyc - ic), (W+2)'(N));
                    end
                end
            end
        end

        initial begin
            logic [W-1:0] max_pos, min_neg, one, five, seven;
            logic [W+1:0] e1;
            int           t;
            int           nwait;
            max_pos = {1'b0, {(W-1){1'b1}}};
            min_neg = ~max_pos;
            one     = W'(1);
            five    = W'(5);
            seven   = W'(7);
            fin[k]  = 1'b0;

            rst = 1'b1;
            tick();
            tick();
            rst = 1'b0;
            chk("reset_outs", {busy, done, cout, ovf, sum}, '0);

            // Directed corner operations.
            issue('1, one, 1'b0, 1'b0);      chk("busy_after_accept", (W+2)'(busy), (W+2)'(1)); wait_done(); tick();
            issue(five, seven, 1'b0, 1'b1);  wait_done(); tick();
            issue(five, seven, 1'b1, 1'b1);  wait_done(); tick();
            issue(max_pos, one, 1'b0, 1'b0); wait_done(); tick();
            issue(min_neg, one, 1'b0, 1'b1); wait_done();
            chk("busy_low_at_done", (W+2)'(busy), '0);
            tick();

            // start while busy is ignored.
            issue(rnd_op(), rnd_op(), 1'b0, 1'b0);
            a = rnd_op(); b = rnd_op(); sub = 1'b1; start = 1'b1;
            tick();
            start = 1'b0;
            wait_done();
            repeat (N + 3) tick();
            chk("idle_after_ignore", (W+2)'(busy), '0);

            // Back-to-back with the first result held during the second run.
            e1 = model(max_pos, one, 1'b1, 1'b0);
            issue(max_pos, one, 1'b1, 1'b0);
            wait_done();
            issue(five, seven, 1'b0, 1'b1);
            chk("b2b_accept", (W+2)'(busy), (W+2)'(1));
            t = 0;
            while (!done && t < N + 8) begin
                chk("hold_prev_result", {cout, ovf, sum}, e1);
                tick();
                t++;
            end
            wait_done();
            tick();

            // Reset in the middle of a run aborts it.
            issue(rnd_op(), rnd_op(), 1'b1, 1'b0);
            nwait = (N > 4) ? 3 : N - 1;
            repeat (nwait) tick();
            rst = 1'b1;
            exp_q.delete();
            iss_q.delete();
            tick();
            rst = 1'b0;
            chk("abort_outs", {busy, done, cout, ovf, sum}, '0);
            repeat (N + 3) tick();
            chk("abort_quiet", {busy, done, cout, ovf, sum}, '0);
            issue(seven, five, 1'b0, 1'b1);
            wait_done();
            tick();

            // Randomised traffic, zero-gap issues exercise back-to-back acceptance.
            repeat (1000) begin
                issue(rnd_op(), rnd_op(), 1'($urandom), 1'($urandom));
                wait_done();
                repeat ($urandom % 3) tick();
            end
            tick();
            tick();
            chk("scoreboard_empty", (W+2)'(exp_q.size()), '0);
            fin[k] = 1'b1;
        end
    end

    initial begin
        int t = 0;
        #1;
        while (!(fin[0] && fin[1] && fin[2] && fin[3]) && t < 90000) begin
            @(posedge clk);
            t++;
        end
        if (!(fin[0] && fin[1] && fin[2] && fin[3])) begin
            checks++;
            errors++;
            $display("FAIL global_timeout: got unfinished configs want all finished");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
